// File: rtl/m3_step_monitor.sv
// m3 step-timing receiver: measures clocks per step, checks the 15,0..11 index sequence, flags overspeed/stall.
// Optional round-length accumulator enabled by defining M3_STEP_MONITOR_AVG_EN.
module m3_step_monitor #(
  parameter int CNT_W        = 22,
  parameter int PERIOD_MIN_P = 40,
  parameter int PERIOD_MAX_P = 4000000,
  parameter int LAST_STEP_P  = 11
) (
  input  logic             clkI,
  input  logic             nRstI,
  input  logic             workingI,
  input  logic             nextStepI,
  input  logic [3:0]       stepI,
  output logic [CNT_W-1:0] periodO,
  output logic             periodValidO,
  output logic             roundDoneO,
  output logic [15:0]      roundCntO,
  output logic             overSpeedO,
  output logic             stallO,
  output logic             seqErrO,
  output logic [CNT_W+3:0] roundLenO
);

  localparam logic [CNT_W-1:0] CNT_ALL1 = {CNT_W{1'b1}};
  localparam logic [CNT_W-1:0] CNT_ONE  = {{(CNT_W-1){1'b0}}, 1'b1};
  localparam logic [CNT_W-1:0] MIN_C    = CNT_W'(PERIOD_MIN_P);
  localparam logic [CNT_W-1:0] MAX_C    = CNT_W'(PERIOD_MAX_P);
  localparam logic [3:0]       LAST_C   = 4'(LAST_STEP_P);

  logic [CNT_W-1:0] cnt_r;
  logic [CNT_W-1:0] cntInc_s;
  logic [3:0]       expStep_r;
  logic [3:0]       nextExp_s;
  logic             first_r;
  logic             isLast_s;
  logic             mismatch_s;
  logic [CNT_W-1:0] period_r;
  logic             periodValid_r;
  logic             roundDone_r;
  logic [15:0]      roundCnt_r;
  logic             overSpeed_r;
  logic             stall_r;
  logic             seqErr_r;

  // Next-state helpers: saturating count and expected-index tracking
  always_comb begin
    cntInc_s   = (cnt_r == CNT_ALL1) ? cnt_r : (cnt_r + CNT_ONE);
    isLast_s   = (stepI == LAST_C);
    mismatch_s = (stepI != expStep_r);
    nextExp_s  = isLast_s ? 4'd0 : (stepI + 4'd1);
  end

  // Period counter, sequence tracking and status flags
  always_ff @(posedge clkI or negedge nRstI) begin
    if (!nRstI) begin
      cnt_r         <= CNT_ONE;
      expStep_r     <= 4'hF;
      first_r       <= 1'b1;
      period_r      <= {CNT_W{1'b0}};
      periodValid_r <= 1'b0;
      roundDone_r   <= 1'b0;
      roundCnt_r    <= 16'd0;
      overSpeed_r   <= 1'b0;
      stall_r       <= 1'b0;
      seqErr_r      <= 1'b0;
    end else if (!workingI) begin
      cnt_r         <= CNT_ONE;
      expStep_r     <= 4'hF;
      first_r       <= 1'b1;
      period_r      <= {CNT_W{1'b0}};
      periodValid_r <= 1'b0;
      roundDone_r   <= 1'b0;
      roundCnt_r    <= 16'd0;
      overSpeed_r   <= 1'b0;
      stall_r       <= 1'b0;
      seqErr_r      <= 1'b0;
    end else begin
      periodValid_r <= 1'b0;
      roundDone_r   <= 1'b0;
      if (nextStepI) begin
        cnt_r     <= CNT_ONE;
        expStep_r <= nextExp_s;
        first_r   <= 1'b0;
        stall_r   <= 1'b0;
        if (mismatch_s) begin
          seqErr_r <= 1'b1;
        end
        // The very first strobe only anchors the period measurement
        if (!first_r) begin
          period_r      <= cnt_r;
          periodValid_r <= 1'b1;
          overSpeed_r   <= (cnt_r < MIN_C);
          if (isLast_s) begin
            roundDone_r <= 1'b1;
            if (roundCnt_r != 16'hFFFF) begin
              roundCnt_r <= roundCnt_r + 16'd1;
            end
          end
        end
      end else begin
        cnt_r <= cntInc_s;
        // Flag goes high as the counter steps past the maximum legal period
        if (cnt_r >= MAX_C) begin
          stall_r <= 1'b1;
        end
      end
    end
  end

`ifdef M3_STEP_MONITOR_AVG_EN
  logic [CNT_W+3:0] acc_r;
  logic [CNT_W+3:0] roundLen_r;
  logic [CNT_W+3:0] cntExt_s;
  logic             accOk_r;

  assign cntExt_s = {4'd0, cnt_r};

  // Sum of step periods over a clean round, published at the last step
  always_ff @(posedge clkI or negedge nRstI) begin
    if (!nRstI) begin
      acc_r      <= {(CNT_W+4){1'b0}};
      roundLen_r <= {(CNT_W+4){1'b0}};
      accOk_r    <= 1'b0;
    end else if (!workingI) begin
      acc_r      <= {(CNT_W+4){1'b0}};
      roundLen_r <= {(CNT_W+4){1'b0}};
      accOk_r    <= 1'b0;
    end else if (nextStepI) begin
      if (first_r) begin
        acc_r   <= {(CNT_W+4){1'b0}};
        accOk_r <= !mismatch_s;
      end else if (isLast_s) begin
        if (accOk_r && !mismatch_s) begin
          roundLen_r <= acc_r + cntExt_s;
        end
        acc_r   <= {(CNT_W+4){1'b0}};
        accOk_r <= 1'b1;
      end else begin
        acc_r <= acc_r + cntExt_s;
        if (mismatch_s) begin
          accOk_r <= 1'b0;
        end
      end
    end
  end

  assign roundLenO = roundLen_r;
`else
  assign roundLenO = {(CNT_W+4){1'b0}};
`endif

  assign periodO      = period_r;
  assign periodValidO = periodValid_r;
  assign roundDoneO   = roundDone_r;
  assign roundCntO    = roundCnt_r;
  assign overSpeedO   = overSpeed_r;
  assign stallO       = stall_r;
  assign seqErrO      = seqErr_r;

endmodule

// File: tb/tb_m3_step_monitor.sv
// Bench for m3_step_monitor: timestamp-based reference model checked every cycle, plus literal spot checks.
module tb_m3_step_monitor;

  localparam int    CW    = 22;
  localparam int    MINP  = 40;
  localparam int    MAXP  = 1000;
  localparam int    LASTP = 11;
  localparam longint SATV = (64'd1 << CW) - 1;
`ifdef M3_STEP_MONITOR_AVG_EN
  localparam bit AVG = 1'b1;
`else
  localparam bit AVG = 1'b0;
`endif

  logic          clkI = 1'b0;
  logic          nRstI = 1'b0;
  logic          workingI = 1'b0;
  logic          nextStepI = 1'b0;
  logic [3:0]    stepI = 4'd0;
  logic [CW-1:0] periodO;
  logic          periodValidO, roundDoneO, overSpeedO, stallO, seqErrO;
  logic [15:0]   roundCntO;
  logic [CW+3:0] roundLenO;

  // Narrow-counter instance used only to observe period saturation
  logic [7:0]    sPeriod;
  logic          sValid, sDone, sOver, sStall, sSeq;
  logic [15:0]   sRounds;
  logic [11:0]   sLen;

  m3_step_monitor #(.CNT_W(CW), .PERIOD_MIN_P(MINP), .PERIOD_MAX_P(MAXP), .LAST_STEP_P(LASTP)) dut (
    .clkI(clkI), .nRstI(nRstI), .workingI(workingI), .nextStepI(nextStepI), .stepI(stepI),
    .periodO(periodO), .periodValidO(periodValidO), .roundDoneO(roundDoneO), .roundCntO(roundCntO),
    .overSpeedO(overSpeedO), .stallO(stallO), .seqErrO(seqErrO), .roundLenO(roundLenO));

  m3_step_monitor #(.CNT_W(8), .PERIOD_MIN_P(MINP), .PERIOD_MAX_P(200), .LAST_STEP_P(LASTP)) dutSmall (
    .clkI(clkI), .nRstI(nRstI), .workingI(workingI), .nextStepI(nextStepI), .stepI(stepI),
    .periodO(sPeriod), .periodValidO(sValid), .roundDoneO(sDone), .roundCntO(sRounds),
    .overSpeedO(sOver), .stallO(sStall), .seqErrO(sSeq), .roundLenO(sLen));

  always #5 clkI = ~clkI;

  int total = 0;
  int bad   = 0;

  task automatic check(input string name, input logic [31:0] act, input logic [31:0] exp);
    total++;
    if (act !== exp) begin
      bad++;
      $display("FAIL %s: got %0d want %0d (t=%0t)", name, act, exp, $time);
    end
  endtask

  // Reference model state: time of last anchor instead of a running counter
  longint cyc = 0, baseT = 0, mSum = 0, mRoundLen = 0;
  bit     mFirst = 1'b1, mValid, mDone, mOver, mStall, mSeq, mClean;
  logic [3:0] mExp = 4'hF;
  longint mPeriod = 0;
  int     mRounds = 0;
  int     validCnt = 0, doneCnt = 0;

  always @(posedge clkI) begin : model
    longint el;
    cyc++;
    if (!nRstI || !workingI) begin
      mFirst = 1'b1; mExp = 4'hF; baseT = cyc; mPeriod = 0; mValid = 0; mDone = 0;
      mOver = 0; mStall = 0; mSeq = 0; mRounds = 0; mSum = 0; mRoundLen = 0; mClean = 0;
    end else begin
      el = cyc - baseT;
      if (el > SATV) el = SATV;
      mValid = 0;
      mDone  = 0;
      if (nextStepI) begin
        if (stepI != mExp) begin
          mSeq = 1; mClean = 0;
        end
        if (mFirst) begin
          mFirst = 0; mSum = 0; mClean = (stepI == 4'd15);
        end else begin
          mPeriod = el; mValid = 1; mOver = (el < MINP); mSum += el;
          if (stepI == LASTP) begin
            mDone = 1;
            if (mRounds < 65535) mRounds++;
            if (mClean) mRoundLen = mSum;
            mSum = 0; mClean = 1;
          end
        end
        mStall = 0;
        mExp = (stepI == LASTP) ? 4'd0 : 4'(stepI + 4'd1);
        baseT = cyc;
      end else if (el >= MAXP) begin
        mStall = 1;
      end
    end
    #1;
    if (nRstI) begin
      check("period", periodO, 32'(mPeriod));
      check("periodValid", periodValidO, mValid);
      check("roundDone", roundDoneO, mDone);
      check("roundCnt", roundCntO, mRounds);
      check("overSpeed", overSpeedO, mOver);
      check("stall", stallO, mStall);
      check("seqErr", seqErrO, mSeq);
      check("roundLen", roundLenO, AVG ? 32'(mRoundLen) : 32'd0);
      validCnt += int'(periodValidO);
      doneCnt  += int'(roundDoneO);
    end
  end

  task automatic strobeAfter(input int n, input logic [3:0] s);
    repeat (n - 1) begin
      @(negedge clkI);
      nextStepI = 1'b0;
    end
    @(negedge clkI);
    nextStepI = 1'b1;
    stepI = s;
  endtask

  task automatic idle(input int n);
    repeat (n) begin
      @(negedge clkI);
      nextStepI = 1'b0;
    end
  endtask

  initial begin
    // 1: reset and idle with random strobes
    repeat (3) @(negedge clkI);
    check("rst_period", periodO, 0);
    check("rst_roundCnt", roundCntO, 0);
    check("rst_flags", {periodValidO, roundDoneO, overSpeedO, stallO, seqErrO}, 0);
    nRstI = 1'b1;
    for (int i = 0; i < 20; i++) begin
      @(negedge clkI);
      nextStepI = 1'($urandom_range(0, 1));
      stepI = 4'($urandom_range(0, 15));
    end
    idle(1);
    check("idle_roundCnt", roundCntO, 0);
    check("idle_seqErr", seqErrO, 0);
    check("idle_valid_tally", validCnt, 0);

    // 2: one full round at 300 clk/step, first strobe coincides with workingI rising
    @(negedge clkI);
    workingI = 1'b1; nextStepI = 1'b1; stepI = 4'd15;
    for (int i = 0; i < 12; i++) strobeAfter(300, 4'(i));
    idle(1);
    check("r1_valid_tally", validCnt, 12);
    check("r1_done_tally", doneCnt, 1);
    check("r1_roundCnt", roundCntO, 1);
    check("r1_period", periodO, 300);
    check("r1_roundLen", roundLenO, AVG ? 32'd3600 : 32'd0);

    // 3: overspeed set at 30 clk, cleared at 300, set again for back-to-back strobes
    strobeAfter(29, 4'd0);
    strobeAfter(30, 4'd1);
    idle(1);
    check("os_set", overSpeedO, 1);
    check("os_period", periodO, 30);
    strobeAfter(299, 4'd2);
    idle(1);
    check("os_clear", overSpeedO, 0);
    strobeAfter(99, 4'd3);
    strobeAfter(1, 4'd4);
    idle(1);
    check("b2b_period", periodO, 1);
    check("b2b_over", overSpeedO, 1);

    // 4: stall after PERIOD_MAX_P quiet cycles, cleared by the next strobe
    strobeAfter(299, 4'd5);
    repeat (MAXP) begin
      @(negedge clkI);
      nextStepI = 1'b0;
    end
    check("stall_before", stallO, 0);
    @(negedge clkI);
    check("stall_set", stallO, 1);
    nextStepI = 1'b1; stepI = 4'd6;
    idle(1);
    check("stall_clear", stallO, 0);
    check("stall_period", periodO, MAXP + 1);
    check("sat_period", sPeriod, 255);
    strobeAfter(299, 4'd7);
    for (int i = 8; i <= 11; i++) strobeAfter(300, 4'(i));
    idle(1);
    check("r2_roundCnt", roundCntO, 2);
    check("r2_done_tally", doneCnt, 2);

    // 5: sequence 15,0,1,3 sets sticky seqErr, cleared by one idle cycle
    @(negedge clkI);
    workingI = 1'b0; nextStepI = 1'b0;
    @(negedge clkI);
    workingI = 1'b1; nextStepI = 1'b1; stepI = 4'd15;
    strobeAfter(200, 4'd0);
    strobeAfter(200, 4'd1);
    idle(1);
    check("seq_ok", seqErrO, 0);
    strobeAfter(199, 4'd3);
    idle(1);
    check("seq_set", seqErrO, 1);
    strobeAfter(199, 4'd4);
    idle(1);
    check("seq_sticky", seqErrO, 1);
    @(negedge clkI);
    workingI = 1'b0;
    @(negedge clkI);
    check("seq_cleared", seqErrO, 0);
    check("seq_roundCnt", roundCntO, 0);

    // 6: drop workingI mid-round at step 5; nothing pending may escape
    workingI = 1'b1; nextStepI = 1'b1; stepI = 4'd15;
    for (int i = 0; i < 5; i++) strobeAfter(100, 4'(i));
    idle(99);
    @(negedge clkI);
    workingI = 1'b0; nextStepI = 1'b1; stepI = 4'd5;
    @(negedge clkI);
    stepI = 4'd11;
    idle(1);
    check("drop_period", periodO, 0);
    check("drop_flags", {periodValidO, roundDoneO, overSpeedO, stallO, seqErrO}, 0);
    idle(5);
    check("drop_done_tally", doneCnt, 2);

    $display("test done: total=%0d bad=%0d", total, bad);
    $finish;
  end

endmodule
